// File: rtl/dual_spectrum_pingpong_buffer.sv
// dual_spectrum_pingpong_buffer: per-channel ping-pong spectrum frame store with vsync-aligned swap and peak tracking
module dual_spectrum_pingpong_buffer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int PEAK_BINS  = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ch1_wr_data,
    input  logic [ADDR_WIDTH-1:0] ch1_wr_addr,
    input  logic                  ch1_wr_valid,
    input  logic [DATA_WIDTH-1:0] ch2_wr_data,
    input  logic [ADDR_WIDTH-1:0] ch2_wr_addr,
    input  logic                  ch2_wr_valid,
    input  logic                  frame_sync,
    input  logic                  rd_en,
    input  logic                  rd_ch,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  ch1_frame_ready,
    output logic                  ch2_frame_ready,
    output logic [DATA_WIDTH-1:0] ch1_peak_mag,
    output logic [DATA_WIDTH-1:0] ch2_peak_mag,
    output logic [ADDR_WIDTH-1:0] ch1_peak_bin,
    output logic [ADDR_WIDTH-1:0] ch2_peak_bin,
    output logic                  ch1_overrun,
    output logic                  ch2_overrun,
    output logic                  ch1_drop,
    output logic                  ch2_drop
);
    localparam int N = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DONE} wstate_t;

    logic [DATA_WIDTH-1:0] wr_data [2];
    logic [ADDR_WIDTH-1:0] wr_addr [2];
    logic [DATA_WIDTH-1:0] peak_mag [2];
    logic [ADDR_WIDTH-1:0] peak_bin [2];
    logic [1:0] wr_valid, we, disp, ready, overrun, drop;
    logic [DATA_WIDTH-1:0] mem1 [2*N];
    logic [DATA_WIDTH-1:0] mem2 [2*N];

    assign wr_data[0] = ch1_wr_data;
    assign wr_data[1] = ch2_wr_data;
    assign wr_addr[0] = ch1_wr_addr;
    assign wr_addr[1] = ch2_wr_addr;
    assign wr_valid   = {ch2_wr_valid, ch1_wr_valid};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_ch
            wstate_t state, nstate;
            logic [ADDR_WIDTH-1:0] a, expected, tbin, nbin, pbin, obin;
            logic [DATA_WIDTH-1:0] d, tmax, nmax, pmag, omag;
            logic v, wr, swap, ovr_n, drop_n, in_range, disp_q, ready_q, ovr_q, drop_q;

            assign a = wr_addr[g];
            assign d = wr_data[g];
            assign v = wr_valid[g];

            always_comb begin
                nstate = state;
                wr     = 1'b0;
                swap   = 1'b0;
                ovr_n  = 1'b0;
                drop_n = 1'b0;
                case (state)
                    W_IDLE: if (v && a == '0) begin
                        wr     = 1'b1;
                        nstate = W_FILL;
                    end
                    // a broken sequence that lands on bin 0 restarts the frame in place
                    W_FILL: if (v) begin
                        wr     = (a == expected) || (a == '0);
                        drop_n = (a != expected);
                        nstate = (a == expected) ? ((&a) ? W_DONE : W_FILL)
                                                 : ((a == '0) ? W_FILL : W_IDLE);
                    end
                    W_DONE: begin
                        ovr_n  = v;
                        swap   = frame_sync;
                        nstate = frame_sync ? W_IDLE : W_DONE;
                    end
                    default: nstate = W_IDLE;
                endcase
                in_range = (a != '0) && ({1'b0, a} < (ADDR_WIDTH+1)'(PEAK_BINS));
                nmax = !wr ? tmax : (a == '0) ? '0 : (in_range && d > tmax) ? d : tmax;
                nbin = !wr ? tbin : (a == '0) ? '0 : (in_range && d > tmax) ? a : tbin;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state    <= W_IDLE;
                    expected <= '0;
                    tmax     <= '0;
                    tbin     <= '0;
                    pmag     <= '0;
                    pbin     <= '0;
                    omag     <= '0;
                    obin     <= '0;
                    disp_q   <= 1'b0;
                    ready_q  <= 1'b0;
                    ovr_q    <= 1'b0;
                    drop_q   <= 1'b0;
                end else begin
                    state  <= nstate;
                    tmax   <= nmax;
                    tbin   <= nbin;
                    ovr_q  <= ovr_n;
                    drop_q <= drop_n;
                    if (wr) expected <= a + ADDR_WIDTH'(1);
                    if (wr && (&a)) begin
                        pmag <= nmax;
                        pbin <= nbin;
                    end
                    if (swap) begin
                        disp_q  <= ~disp_q;
                        ready_q <= 1'b1;
                        omag    <= pmag;
                        obin    <= pbin;
                    end
                end
            end

            assign we[g]       = wr;
            assign disp[g]     = disp_q;
            assign ready[g]    = ready_q;
            assign overrun[g]  = ovr_q;
            assign drop[g]     = drop_q;
            assign peak_mag[g] = omag;
            assign peak_bin[g] = obin;
        end
    endgenerate

    // writes always land in the bank the display is not reading
    always_ff @(posedge clk) begin
        if (we[0]) mem1[{~disp[0], ch1_wr_addr}] <= ch1_wr_data;
        if (we[1]) mem2[{~disp[1], ch2_wr_addr}] <= ch2_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_en;
            if (rd_en) rd_data <= rd_ch ? mem2[{disp[1], rd_addr}] : mem1[{disp[0], rd_addr}];
        end
    end

    assign ch1_frame_ready = ready[0];
    assign ch2_frame_ready = ready[1];
    assign ch1_peak_mag    = peak_mag[0];
    assign ch2_peak_mag    = peak_mag[1];
    assign ch1_peak_bin    = peak_bin[0];
    assign ch2_peak_bin    = peak_bin[1];
    assign ch1_overrun     = overrun[0];
    assign ch2_overrun     = overrun[1];
    assign ch1_drop        = drop[0];
    assign ch2_drop        = drop[1];
endmodule

// File: tb/tb_dual_spectrum_pingpong_buffer.sv
// tb_dual_spectrum_pingpong_buffer: directed scenario bench for the dual-channel ping-pong spectrum buffer
module tb_dual_spectrum_pingpong_buffer;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int N  = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] ch1_wr_data = '0, ch2_wr_data = '0;
    logic [AW-1:0] ch1_wr_addr = '0, ch2_wr_addr = '0;
    logic          ch1_wr_valid = 1'b0, ch2_wr_valid = 1'b0;
    logic          frame_sync = 1'b0, rd_en = 1'b0, rd_ch = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data, ch1_peak_mag, ch2_peak_mag;
    logic [AW-1:0] ch1_peak_bin, ch2_peak_bin;
    logic          rd_data_valid, ch1_frame_ready, ch2_frame_ready;
    logic          ch1_overrun, ch2_overrun, ch1_drop, ch2_drop;

    int checks = 0;
    int errors = 0;

    dual_spectrum_pingpong_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .ch1_wr_data(ch1_wr_data), .ch1_wr_addr(ch1_wr_addr), .ch1_wr_valid(ch1_wr_valid),
        .ch2_wr_data(ch2_wr_data), .ch2_wr_addr(ch2_wr_addr), .ch2_wr_valid(ch2_wr_valid),
        .frame_sync(frame_sync), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .ch1_frame_ready(ch1_frame_ready), .ch2_frame_ready(ch2_frame_ready),
        .ch1_peak_mag(ch1_peak_mag), .ch2_peak_mag(ch2_peak_mag),
        .ch1_peak_bin(ch1_peak_bin), .ch2_peak_bin(ch2_peak_bin),
        .ch1_overrun(ch1_overrun), .ch2_overrun(ch2_overrun),
        .ch1_drop(ch1_drop), .ch2_drop(ch2_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int addr, input int data);
        if (ch == 0) begin
            ch1_wr_valid = 1'b1; ch1_wr_addr = AW'(addr); ch1_wr_data = DW'(data);
        end else begin
            ch2_wr_valid = 1'b1; ch2_wr_addr = AW'(addr); ch2_wr_data = DW'(data);
        end
        tick();
        ch1_wr_valid = 1'b0;
        ch2_wr_valid = 1'b0;
    endtask

    task automatic sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic rd(input int ch, input int addr);
        rd_en = 1'b1; rd_ch = ch[0]; rd_addr = AW'(addr);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if ({ch1_frame_ready, ch2_frame_ready, rd_data_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {ch1_frame_ready, ch2_frame_ready, rd_data_valid}); end
        checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
        checks++; if ({ch1_peak_mag, ch2_peak_mag} !== 32'd0 || {ch1_peak_bin, ch2_peak_bin} !== 20'd0) begin errors++; $display("FAIL reset_peaks: got %h/%h expected 0", {ch1_peak_mag, ch2_peak_mag}, {ch1_peak_bin, ch2_peak_bin}); end
        checks++; if ({ch1_overrun, ch2_overrun, ch1_drop, ch2_drop} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {ch1_overrun, ch2_overrun, ch1_drop, ch2_drop}); end
    endtask

    task automatic test_basic_frame();
        for (int a = 0; a < N; a++) send(0, a, a);
        checks++; if (ch1_frame_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_presync: got %b expected 0", ch1_frame_ready); end
        sync();
        checks++; if (ch1_frame_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", ch1_frame_ready); end
        checks++; if (ch1_peak_mag !== 16'd511 || ch1_peak_bin !== 10'd511) begin errors++; $display("FAIL basic_peak: got %0d@%0d expected 511@511", ch1_peak_mag, ch1_peak_bin); end
        checks++; if (ch2_frame_ready !== 1'b0) begin errors++; $display("FAIL basic_ch2_ready: got %b expected 0", ch2_frame_ready); end
        rd(0, 5);
        checks++; if (rd_data !== 16'd5 || rd_data_valid !== 1'b1) begin errors++; $display("FAIL basic_read: got %0d v%b expected 5 v1", rd_data, rd_data_valid); end
        tick();
        checks++; if (rd_data !== 16'd5 || rd_data_valid !== 1'b0) begin errors++; $display("FAIL basic_hold: got %0d v%b expected 5 v0", rd_data, rd_data_valid); end
    endtask

    task automatic test_mid_join();
        int drops = 0;
        for (int a = 100; a < N; a++) begin send(1, a, 1000 + a); drops += int'(ch2_drop); end
        for (int a = 0; a < N; a++) begin send(1, a, 2000 + a); drops += int'(ch2_drop); end
        checks++; if (drops !== 0) begin errors++; $display("FAIL join_drops: got %0d expected 0", drops); end
        checks++; if (ch2_frame_ready !== 1'b0) begin errors++; $display("FAIL join_ready_presync: got %b expected 0", ch2_frame_ready); end
        sync();
        checks++; if (ch2_frame_ready !== 1'b1) begin errors++; $display("FAIL join_ready: got %b expected 1", ch2_frame_ready); end
        checks++; if (ch2_peak_mag !== 16'd2511 || ch2_peak_bin !== 10'd511) begin errors++; $display("FAIL join_peak: got %0d@%0d expected 2511@511", ch2_peak_mag, ch2_peak_bin); end
        checks++; if (ch1_peak_mag !== 16'd511) begin errors++; $display("FAIL join_ch1_peak_kept: got %0d expected 511", ch1_peak_mag); end
        rd(1, 0);
        checks++; if (rd_data !== 16'd2000) begin errors++; $display("FAIL join_read0: got %0d expected 2000", rd_data); end
        rd(1, 1023);
        checks++; if (rd_data !== 16'd3023) begin errors++; $display("FAIL join_read1023: got %0d expected 3023", rd_data); end
        rd(0, 5);
        checks++; if (rd_data !== 16'd5) begin errors++; $display("FAIL join_ch1_read: got %0d expected 5", rd_data); end
    endtask

    task automatic test_overrun();
        int ov = 0;
        for (int a = 0; a < N; a++) send(0, a, 4000 + a);
        for (int a = 0; a < N; a++) begin send(0, a, 5000 + a); ov += int'(ch1_overrun); end
        checks++; if (ov !== 1024) begin errors++; $display("FAIL overrun_count: got %0d expected 1024", ov); end
        ch1_wr_valid = 1'b1; ch1_wr_addr = '0; ch1_wr_data = 16'd9999; frame_sync = 1'b1;
        tick();
        ch1_wr_valid = 1'b0; frame_sync = 1'b0;
        checks++; if (ch1_overrun !== 1'b1) begin errors++; $display("FAIL overrun_at_sync: got %b expected 1", ch1_overrun); end
        checks++; if (ch1_peak_mag !== 16'd4511 || ch1_peak_bin !== 10'd511) begin errors++; $display("FAIL overrun_peak: got %0d@%0d expected 4511@511", ch1_peak_mag, ch1_peak_bin); end
        rd(0, 5);
        checks++; if (rd_data !== 16'd4005) begin errors++; $display("FAIL overrun_read5: got %0d expected 4005", rd_data); end
        rd(0, 0);
        checks++; if (rd_data !== 16'd4000) begin errors++; $display("FAIL overrun_read0: got %0d expected 4000", rd_data); end
        ov = 0;
        for (int a = 0; a < N; a++) begin send(0, a, 6000 + a); ov += int'(ch1_overrun); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL refill_overruns: got %0d expected 0", ov); end
        sync();
        rd(0, 1023);
        checks++; if (rd_data !== 16'd7023) begin errors++; $display("FAIL refill_read: got %0d expected 7023", rd_data); end
        checks++; if (ch1_peak_mag !== 16'd6511) begin errors++; $display("FAIL refill_peak: got %0d expected 6511", ch1_peak_mag); end
    endtask

    task automatic test_drop();
        reset_dut();
        for (int a = 0; a < 10; a++) send(0, a, a);
        checks++; if (ch1_drop !== 1'b0) begin errors++; $display("FAIL drop_early: got %b expected 0", ch1_drop); end
        send(0, 12, 12);
        checks++; if (ch1_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", ch1_drop); end
        tick();
        checks++; if (ch1_drop !== 1'b0) begin errors++; $display("FAIL drop_width: got %b expected 0", ch1_drop); end
        send(0, 13, 13);
        checks++; if (ch1_drop !== 1'b0) begin errors++; $display("FAIL drop_idle_discard: got %b expected 0", ch1_drop); end
        sync();
        checks++; if (ch1_frame_ready !== 1'b0) begin errors++; $display("FAIL drop_no_swap: got %b expected 0", ch1_frame_ready); end
        checks++; if (ch1_peak_mag !== 16'd0 || ch1_peak_bin !== 10'd0) begin errors++; $display("FAIL drop_peak: got %0d@%0d expected 0@0", ch1_peak_mag, ch1_peak_bin); end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < N; a++) begin
            ch1_wr_valid = 1'b1; ch1_wr_addr = AW'(a); ch1_wr_data = (a == 7 || a == 9) ? 16'hFFFF : DW'(a);
            ch2_wr_valid = 1'b1; ch2_wr_addr = AW'(a); ch2_wr_data = DW'(1000 + a);
            tick();
        end
        ch1_wr_valid = 1'b0; ch2_wr_valid = 1'b0;
        checks++; if ({ch1_frame_ready, ch2_frame_ready} !== 2'b00) begin errors++; $display("FAIL b2b_presync: got %b expected 00", {ch1_frame_ready, ch2_frame_ready}); end
        sync();
        checks++; if ({ch1_frame_ready, ch2_frame_ready} !== 2'b11) begin errors++; $display("FAIL b2b_ready: got %b expected 11", {ch1_frame_ready, ch2_frame_ready}); end
        checks++; if (ch1_peak_mag !== 16'hFFFF || ch1_peak_bin !== 10'd7) begin errors++; $display("FAIL b2b_tie_peak: got %h@%0d expected ffff@7", ch1_peak_mag, ch1_peak_bin); end
        checks++; if (ch2_peak_mag !== 16'd1511 || ch2_peak_bin !== 10'd511) begin errors++; $display("FAIL b2b_ch2_peak: got %0d@%0d expected 1511@511", ch2_peak_mag, ch2_peak_bin); end
        rd_en = 1'b1; rd_ch = 1'b0; rd_addr = 10'd3;
        tick();
        checks++; if (rd_data !== 16'd3 || rd_data_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_ch1: got %0d v%b expected 3 v1", rd_data, rd_data_valid); end
        rd_ch = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== 16'd1003 || rd_data_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_ch2: got %0d v%b expected 1003 v1", rd_data, rd_data_valid); end
        tick();
        checks++; if (rd_data !== 16'd1003 || rd_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold: got %0d v%b expected 1003 v0", rd_data, rd_data_valid); end
        rd(0, 9);
        checks++; if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL b2b_rd_bin9: got %h expected ffff", rd_data); end
    endtask

    task automatic test_async_reset();
        for (int a = 0; a <= 500; a++) send(0, a, a);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({ch1_frame_ready, ch2_frame_ready, rd_data_valid} !== 3'b000 || rd_data !== 16'd0) begin errors++; $display("FAIL areset_flags: got %b data %0d expected 000 data 0", {ch1_frame_ready, ch2_frame_ready, rd_data_valid}, rd_data); end
        checks++; if ({ch1_peak_mag, ch2_peak_mag} !== 32'd0 || {ch1_peak_bin, ch2_peak_bin} !== 20'd0) begin errors++; $display("FAIL areset_peaks: got %h/%h expected 0", {ch1_peak_mag, ch2_peak_mag}, {ch1_peak_bin, ch2_peak_bin}); end
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < N; a++) send(0, a, 8000 + a);
        checks++; if (ch1_frame_ready !== 1'b0) begin errors++; $display("FAIL areset_presync: got %b expected 0", ch1_frame_ready); end
        sync();
        checks++; if (ch1_frame_ready !== 1'b1 || ch1_peak_mag !== 16'd8511 || ch1_peak_bin !== 10'd511) begin errors++; $display("FAIL areset_frame: got r%b %0d@%0d expected r1 8511@511", ch1_frame_ready, ch1_peak_mag, ch1_peak_bin); end
        rd(0, 500);
        checks++; if (rd_data !== 16'd8500) begin errors++; $display("FAIL areset_read: got %0d expected 8500", rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_mid_join();
        test_overrun();
        test_drop();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
